// File: rtl/axis_video_pattern_gen_pkg.sv
// Shared constants for the AXI4-Stream test-pattern source: pattern codes,
// colour-bar palette, FSM encoding and counter-width helpers.
package axis_video_pattern_gen_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_MBAR  = 2'd3
  } pat_sel_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Left-to-right SMPTE-style order: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A 1-pixel or 1-line raster still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/axis_video_pattern_gen_raster_xy_counter.sv
// Raster position counter. Holds the coordinate of the pixel currently on the
// bus; sof/eol describe the position reached on the next step, eof the current one.
module raster_xy_counter
  import axis_video_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  localparam int XW = cnt_width(H_ACTIVE),
  localparam int YW = cnt_width(V_ACTIVE)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          step_i,
  output logic [XW-1:0] x_nxt_o,
  output logic          sof_o,
  output logic          eol_o,
  output logic          eof_o
);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_last, y_last;

  assign x_last = (x_q == X_LAST);
  assign y_last = (y_q == Y_LAST);

  always_comb begin
    x_d = x_last ? '0 : x_q + 1'b1;
    y_d = y_q;
    if (x_last) y_d = y_last ? '0 : y_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (step_i) begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_nxt_o = x_d;
  assign sof_o   = (x_d == '0) && (y_d == '0);
  assign eol_o   = (x_d == X_LAST);
  assign eof_o   = x_last && y_last;

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream test-pattern source, one pixel per accepted beat.
// State | meaning: IDLE | no beat offered, waiting for enable_i ; ACTIVE | frame in progress, beat on bus
module axis_video_pattern_gen
  import axis_video_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE        = 1920,
  parameter int V_ACTIVE        = 1080,
  parameter int DATA_WIDTH      = 24,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic [1:0]                 pattern_sel_i,
  input  logic [DATA_WIDTH-1:0]      color_i,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o,
  output logic                       busy_o
);

  localparam int XW    = cnt_width(H_ACTIVE);
  localparam int BAR_W = H_ACTIVE / 8;

  state_e                       state_q;
  pat_sel_e                     sel_q, sel_in, sel_use;
  logic [DATA_WIDTH-1:0]        color_q, color_use;
  logic [DATA_WIDTH-1:0]        tdata_q;
  logic                         tvalid_q, tuser_q, tlast_q, busy_q;
  logic [FRAME_CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
  logic                         xfer;
  logic [XW-1:0]                x_nxt;
  logic                         sof, eol, eof;

  function automatic logic [DATA_WIDTH-1:0] pixel_f(
    input pat_sel_e                   sel,
    input logic [DATA_WIDTH-1:0]      color,
    input logic [XW-1:0]              x,
    input logic [FRAME_CNT_WIDTH-1:0] fc
  );
    logic [31:0]           xi;
    logic [2:0]            bar;
    logic [7:0]            g;
    logic [DATA_WIDTH-1:0] pix;
    xi  = 32'(x);
    g   = 8'(x);
    bar = '0;
    // Threshold chain instead of a divider since H_ACTIVE/8 need not be a power of two.
    for (int k = 1; k < 8; k++) begin
      if (xi >= 32'(k * BAR_W)) bar = 3'(k);
    end
    pix = '0;
    case (sel)
      PAT_BARS:  pix = DATA_WIDTH'(BAR_RGB[bar]);
      PAT_GRAD:  pix = DATA_WIDTH'({g, g, g});
      PAT_SOLID: pix = color;
      PAT_MBAR:  pix = (4'(xi >> 6) == 4'(fc)) ? DATA_WIDTH'(24'hFFFFFF) : '0;
      default:   pix = '0;
    endcase
    return pix;
  endfunction

  assign sel_in      = pat_sel_e'(pattern_sel_i);
  assign xfer        = tvalid_q && m_axis_tready;
  assign frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(xfer && eof);
  // Pattern and colour are re-sampled only when a new frame's first pixel is built.
  assign sel_use     = sof ? sel_in  : sel_q;
  assign color_use   = sof ? color_i : color_q;

  raster_xy_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_xy (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .step_i  (xfer),
    .x_nxt_o (x_nxt),
    .sof_o   (sof),
    .eol_o   (eol),
    .eof_o   (eof)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sel_q       <= PAT_BARS;
      color_q     <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_q  <= ACTIVE;
            sel_q    <= sel_in;
            color_q  <= color_i;
            tdata_q  <= pixel_f(sel_in, color_i, '0, frame_cnt_d);
            tvalid_q <= 1'b1;
            tuser_q  <= 1'b1;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        ACTIVE: begin
          if (xfer) begin
            if (eof && !enable_i) begin
              state_q  <= IDLE;
              tvalid_q <= 1'b0;
              tuser_q  <= 1'b0;
              tlast_q  <= 1'b0;
              busy_q   <= 1'b0;
            end else begin
              sel_q   <= sel_use;
              color_q <= color_use;
              tdata_q <= pixel_f(sel_use, color_use, x_nxt, frame_cnt_d);
              tuser_q <= sof;
              tlast_q <= eol;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Self-checking bench for axis_video_pattern_gen on a 16x4 raster, with a
// second instance using a 2-bit frame counter for the wrap case.
module tb_axis_video_pattern_gen;

  localparam int H = 16;
  localparam int V = 4;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] color = 24'h0;
  logic        tready = 1'b0;

  logic [23:0] tdata;
  logic        tvalid, tuser, tlast, busy;
  logic [15:0] fc;
  logic [23:0] d2_tdata;
  logic        d2_tvalid, d2_tuser, d2_tlast, d2_busy;
  logic [1:0]  fc2;

  int tests_run = 0;
  int tests_failed = 0;
  int fc_exp = 0;

  logic [23:0] q_data[$];
  bit          q_user[$];
  bit          q_last[$];

  always #5 clk = ~clk;

  axis_video_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_WIDTH(24), .FRAME_CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .pattern_sel_i(pattern_sel), .color_i(color),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast), .frame_cnt_o(fc), .busy_o(busy));

  axis_video_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_WIDTH(24), .FRAME_CNT_WIDTH(2)) dut_w2 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .pattern_sel_i(pattern_sel), .color_i(color),
    .m_axis_tdata(d2_tdata), .m_axis_tvalid(d2_tvalid), .m_axis_tready(tready),
    .m_axis_tuser(d2_tuser), .m_axis_tlast(d2_tlast), .frame_cnt_o(fc2), .busy_o(d2_busy));

  // Reference pixel from the pattern rules, for beat x of a frame whose counter reads fcv.
  function automatic logic [23:0] model_pix(input int sel, input logic [23:0] col, input int x, input int fcv);
    logic [23:0] bars [8];
    int g;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    g = x % 256;
    case (sel)
      0: return bars[x / (H / 8)];
      1: return 24'(g * 65536 + g * 256 + g);
      2: return col;
      default: return (((x / 64) % 16) == (fcv % 16)) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Accept beats with a random stall ratio; records each transferred beat.
  task automatic collect(input int n, input int stall_pct, input int budget, output int got, output int cyc);
    got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      tready = ($urandom_range(0, 99) >= stall_pct);
      if (tvalid === 1'b1 && tready) begin
        q_data.push_back(tdata);
        q_user.push_back(tuser);
        q_last.push_back(tlast);
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic start_frame();
    enable = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_user.delete();
    q_last.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
    tests_run++; if (tuser !== 1'b0) begin tests_failed++; $display("FAIL reset_tuser: got %b want 0", tuser); end
    tests_run++; if (tlast !== 1'b0) begin tests_failed++; $display("FAIL reset_tlast: got %b want 0", tlast); end
    tests_run++; if (tdata !== 24'h0) begin tests_failed++; $display("FAIL reset_tdata: got %h want 000000", tdata); end
    tests_run++; if (fc !== 16'd0) begin tests_failed++; $display("FAIL reset_frame_cnt: got %0d want 0", fc); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    fc_exp = 0;
  endtask

  task automatic test_bars();
    int got, cyc;
    clear_q();
    pattern_sel = 2'd0; tready = 1'b1;
    start_frame();
    tests_run++;
    if (tvalid !== 1'b1 || tuser !== 1'b1 || tdata !== 24'hFFFFFF || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL bars_first_beat: got v=%b u=%b d=%h busy=%b want v=1 u=1 d=ffffff busy=1", tvalid, tuser, tdata, busy);
    end
    enable = 1'b0;
    collect(NPIX, 0, 200, got, cyc);
    tests_run++; if (got != NPIX || cyc != NPIX) begin tests_failed++; $display("FAIL bars_count: got %0d beats in %0d cycles want %0d in %0d", got, cyc, NPIX, NPIX); end
    for (int i = 0; i < q_data.size(); i++) begin
      tests_run++;
      if (q_data[i] !== model_pix(0, 24'h0, i % H, fc_exp) || q_user[i] !== (i == 0) || q_last[i] !== ((i % H) == H - 1)) begin
        tests_failed++;
        $display("FAIL bars_beat%0d: got d=%h u=%b l=%b want d=%h u=%b l=%b", i, q_data[i], q_user[i], q_last[i],
                 model_pix(0, 24'h0, i % H, fc_exp), (i == 0), ((i % H) == H - 1));
      end
    end
    fc_exp++;
    tests_run++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || fc !== 16'(fc_exp)) begin
      tests_failed++;
      $display("FAIL bars_end: got v=%b busy=%b fc=%0d want v=0 busy=0 fc=%0d", tvalid, busy, fc, fc_exp);
    end
  endtask

  task automatic test_backpressure();
    int idx, cyc;
    bit held;
    logic [23:0] h_data;
    logic h_user, h_last;
    pattern_sel = 2'd1;
    start_frame();
    enable = 1'b0;
    idx = 0; cyc = 0; held = 0;
    h_data = '0; h_user = 1'b0; h_last = 1'b0;
    while (idx < NPIX && cyc < 1000) begin
      if (held) begin
        tests_run++;
        if (tvalid !== 1'b1 || tdata !== h_data || tuser !== h_user || tlast !== h_last) begin
          tests_failed++;
          $display("FAIL stall_hold: got v=%b d=%h u=%b l=%b want v=1 d=%h u=%b l=%b", tvalid, tdata, tuser, tlast, h_data, h_user, h_last);
        end
      end
      tready = ($urandom_range(0, 99) >= 30);
      held = 0;
      if (tvalid === 1'b1) begin
        if (tready) begin
          tests_run++;
          if (tdata !== model_pix(1, 24'h0, idx % H, fc_exp) || tuser !== (idx == 0) || tlast !== ((idx % H) == H - 1)) begin
            tests_failed++;
            $display("FAIL grad_beat%0d: got d=%h u=%b l=%b want d=%h", idx, tdata, tuser, tlast, model_pix(1, 24'h0, idx % H, fc_exp));
          end
          idx++;
        end else begin
          held = 1; h_data = tdata; h_user = tuser; h_last = tlast;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    fc_exp++;
    tests_run++;
    if (idx != NPIX || tvalid !== 1'b0 || fc !== 16'(fc_exp)) begin
      tests_failed++;
      $display("FAIL grad_end: got beats=%0d v=%b fc=%0d want beats=%0d v=0 fc=%0d", idx, tvalid, fc, NPIX, fc_exp);
    end
  endtask

  task automatic test_enable_drop();
    int g1, g2, cyc;
    logic [23:0] col;
    clear_q();
    col = 24'($urandom);
    pattern_sel = 2'd2; color = col;
    start_frame();
    collect(2 * H + 5, 0, 100, g1, cyc);
    enable = 1'b0;
    collect(NPIX - (2 * H + 5), 0, 100, g2, cyc);
    tests_run++; if (g1 + g2 != NPIX) begin tests_failed++; $display("FAIL drop_count: got %0d want %0d", g1 + g2, NPIX); end
    for (int i = 0; i < q_data.size(); i++) begin
      tests_run++;
      if (q_data[i] !== col || q_user[i] !== (i == 0) || q_last[i] !== ((i % H) == H - 1)) begin
        tests_failed++;
        $display("FAIL drop_beat%0d: got d=%h u=%b l=%b want d=%h", i, q_data[i], q_user[i], q_last[i], col);
      end
    end
    fc_exp++;
    tests_run++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || fc !== 16'(fc_exp)) begin
      tests_failed++;
      $display("FAIL drop_end: got v=%b busy=%b fc=%0d want v=0 busy=0 fc=%0d", tvalid, busy, fc, fc_exp);
    end
    clear_q();
    pattern_sel = 2'd0;
    start_frame();
    collect(NPIX, 0, 100, g1, cyc);
    fc_exp++;
    tests_run++;
    if (g1 != NPIX || cyc != NPIX || tvalid !== 1'b1 || tuser !== 1'b1 || busy !== 1'b1 || tdata !== 24'hFFFFFF || fc !== 16'(fc_exp)) begin
      tests_failed++;
      $display("FAIL b2b_next_sof: got beats=%0d cyc=%0d v=%b u=%b busy=%b d=%h fc=%0d want %0d %0d 1 1 1 ffffff %0d",
               g1, cyc, tvalid, tuser, busy, tdata, fc, NPIX, NPIX, fc_exp);
    end
    enable = 1'b0;
    collect(NPIX, 0, 100, g2, cyc);
    fc_exp++;
    tests_run++;
    if (g2 != NPIX || tvalid !== 1'b0 || fc !== 16'(fc_exp)) begin
      tests_failed++;
      $display("FAIL b2b_end: got beats=%0d v=%b fc=%0d want %0d 0 %0d", g2, tvalid, fc, NPIX, fc_exp);
    end
  endtask

  task automatic test_pattern_latch();
    int g1, g2, g3, cyc;
    clear_q();
    pattern_sel = 2'd2; color = 24'h123456;
    start_frame();
    collect(30, 0, 100, g1, cyc);
    pattern_sel = 2'd1; color = 24'($urandom);
    collect(NPIX - 30, 0, 100, g2, cyc);
    enable = 1'b0;
    collect(NPIX, 0, 100, g3, cyc);
    tests_run++; if (g1 + g2 + g3 != 2 * NPIX) begin tests_failed++; $display("FAIL latch_count: got %0d want %0d", g1 + g2 + g3, 2 * NPIX); end
    for (int i = 0; i < q_data.size(); i++) begin
      logic [23:0] e;
      e = (i < NPIX) ? 24'h123456 : model_pix(1, 24'h0, i % H, fc_exp + 1);
      tests_run++;
      if (q_data[i] !== e || q_user[i] !== ((i % NPIX) == 0)) begin
        tests_failed++;
        $display("FAIL latch_beat%0d: got d=%h u=%b want d=%h u=%b", i, q_data[i], q_user[i], e, ((i % NPIX) == 0));
      end
    end
    fc_exp += 2;
    tests_run++;
    if (tvalid !== 1'b0 || fc !== 16'(fc_exp)) begin
      tests_failed++;
      $display("FAIL latch_end: got v=%b fc=%0d want v=0 fc=%0d", tvalid, fc, fc_exp);
    end
  endtask

  task automatic test_reset_mid();
    int got, cyc;
    clear_q();
    pattern_sel = 2'd0;
    start_frame();
    enable = 1'b0;
    collect(20, 0, 100, got, cyc);
    rst = 1'b1; tready = 1'b0;
    @(posedge clk); #1;
    fc_exp = 0;
    tests_run++;
    if (tvalid !== 1'b0 || fc !== 16'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid: got v=%b fc=%0d busy=%b want v=0 fc=0 busy=0", tvalid, fc, busy);
    end
    rst = 1'b0;
    start_frame();
    tests_run++;
    if (tvalid !== 1'b1 || tuser !== 1'b1 || tdata !== 24'hFFFFFF) begin
      tests_failed++;
      $display("FAIL rst_restart: got v=%b u=%b d=%h want v=1 u=1 d=ffffff", tvalid, tuser, tdata);
    end
    enable = 1'b0;
    clear_q();
    collect(NPIX, 25, 400, got, cyc);
    for (int i = 0; i < q_data.size(); i++) begin
      tests_run++;
      if (q_data[i] !== model_pix(0, 24'h0, i % H, 0) || q_user[i] !== (i == 0) || q_last[i] !== ((i % H) == H - 1)) begin
        tests_failed++;
        $display("FAIL rst_beat%0d: got d=%h u=%b l=%b", i, q_data[i], q_user[i], q_last[i]);
      end
    end
    fc_exp = 1;
    tests_run++;
    if (got != NPIX || fc !== 16'd1) begin
      tests_failed++;
      $display("FAIL rst_refill: got beats=%0d fc=%0d want %0d 1", got, fc, NPIX);
    end
  endtask

  task automatic test_wrap();
    int got, cyc;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fc_exp = 0;
    pattern_sel = 2'd3;
    start_frame();
    for (int f = 0; f < 5; f++) begin
      clear_q();
      if (f == 4) enable = 1'b0;
      collect(NPIX, 0, 100, got, cyc);
      for (int i = 0; i < q_data.size(); i++) begin
        tests_run++;
        if (q_data[i] !== model_pix(3, 24'h0, i % H, f)) begin
          tests_failed++;
          $display("FAIL mbar_f%0d_beat%0d: got %h want %h", f, i, q_data[i], model_pix(3, 24'h0, i % H, f));
        end
      end
      tests_run++;
      if (got != NPIX || fc2 !== 2'((f + 1) % 4) || fc !== 16'(f + 1)) begin
        tests_failed++;
        $display("FAIL wrap_f%0d: got beats=%0d fc2=%0d fc=%0d want %0d %0d %0d", f, got, fc2, fc, NPIX, (f + 1) % 4, f + 1);
      end
    end
    tests_run++;
    if (tvalid !== 1'b0 || d2_tvalid !== 1'b0 || d2_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_end: got v=%b v2=%b busy2=%b want 0 0 0", tvalid, d2_tvalid, d2_busy);
    end
  endtask

  initial begin
    test_reset();
    test_bars();
    test_backpressure();
    test_enable_drop();
    test_pattern_latch();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axis_video_pattern_gen.md
# axis_video_pattern_gen

AXI4-Stream video source that walks the active raster pixel by pixel and emits one RGB pixel per accepted beat, with start-of-frame on `tuser` and end-of-line on `tlast`. It supplies test video to the downstream video DMA/VDMA path. It selects among four test patterns and honours `tready` backpressure. It keeps a free-running frame count that drives the animated pattern and status.

## Interface
- `H_ACTIVE`, 1920: pixels per line; must be a multiple of 8 and at least 8.
- `V_ACTIVE`, 1080: lines per frame; at least 1.
- `DATA_WIDTH`, 24: pixel width, packed as {R[23:16], G[15:8], B[7:0]}.
- `FRAME_CNT_WIDTH`, 16: width of the frame counter.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i` in 1: clock; all logic samples on the rising edge.
- `rst_i` in 1: synchronous active-high reset.
- `enable_i` in 1: run request; acted on only at frame boundaries.
- `pattern_sel_i` in 2: 0 = colour bars, 1 = gradient, 2 = solid, 3 = moving bar.
- `color_i` in DATA_WIDTH: colour used by the solid pattern.
- `m_axis_tdata` out DATA_WIDTH: pixel data.
- `m_axis_tvalid` out 1: beat valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tuser` out 1: start of frame; set on pixel (0,0) only.
- `m_axis_tlast` out 1: end of line; set on x = H_ACTIVE-1.
- `frame_cnt_o` out FRAME_CNT_WIDTH: number of completed frames; wraps.
- `busy_o` out 1: high while a frame is in progress.

## Operation
- A beat transfers when `m_axis_tvalid && m_axis_tready`.
- States:
  - IDLE: `tvalid` = 0.
  - ACTIVE: `tvalid` = 1 and a beat is presented.
- IDLE to ACTIVE: when `enable_i` = 1 is sampled in IDLE, pixel (0,0) is presented with `tuser` = 1 on the next cycle.
- In ACTIVE, on each transfer:
  - x increments.
  - At x = H_ACTIVE-1, x wraps to 0 and y increments.
  - At the last pixel (H_ACTIVE-1, V_ACTIVE-1), y wraps to 0 and `frame_cnt_o` increments.
- After the last-pixel transfer:
  - If `enable_i` = 1 that cycle, pixel (0,0) of the next frame follows immediately, with no bubble.
  - Otherwise the block returns to IDLE.
- Mid-frame deassertion of `enable_i` is ignored; the frame always completes.
- `pattern_sel_i` and `color_i` are latched when pixel (0,0) is loaded and hold for the whole frame.
- Patterns:
  - Colour bars: bar = x / (H_ACTIVE/8), mapping 0..7 to FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Gradient: R = G = B = x[7:0].
  - Solid: the latched `color_i`.
  - Moving bar: FFFFFF when (x >> 6) mod 16 equals `frame_cnt_o`[3:0], else 000000.
- Arithmetic:
  - x is ceil(log2(H_ACTIVE)) bits and y is ceil(log2(V_ACTIVE)) bits, both unsigned.
  - `frame_cnt_o` wraps from 2^FRAME_CNT_WIDTH-1 to 0 with no flag.

## Timing
- All outputs are registered.
- Reset values: `tvalid` = 0, `tuser` = 0, `tlast` = 0, `tdata` = 0, `frame_cnt_o` = 0, `busy_o` = 0, x = y = 0, state = IDLE.
- `rst_i` dominates every other input.
- `rst_i` mid-frame drops `tvalid` the next cycle, abandons the frame, and clears `frame_cnt_o`.
- Latency from `enable_i` sampled high in IDLE to the first valid beat is 1 cycle.
- With `tready` held at 1, throughput is 1 pixel per cycle. A frame takes exactly H_ACTIVE·V_ACTIVE cycles.
- AXI-Stream rules while `tvalid` = 1 and `tready` = 0:
  - `tdata`, `tuser` and `tlast` hold stable.
  - `tvalid` does not drop.
- `tvalid` never depends combinationally on `tready`.
- The next pixel and its flags are computed from the next x/y/frame state and registered on each transfer.
- `busy_o` rises with the first `tvalid` of a frame. It falls in the cycle after the final-pixel transfer when the block returns to IDLE.
- `frame_cnt_o` updates in the cycle after the final-pixel transfer.

## Structure
- Shared header constants:
  - Pattern select codes (PAT_BARS = 0, PAT_GRAD = 1, PAT_SOLID = 2, PAT_MBAR = 3).
  - The 8 colour-bar RGB constants.
  - A state encoding of IDLE = 0, ACTIVE = 1.
  - The `clog2` helper function.
- One sub-module, `raster_xy_counter`:
  - Enabled x/y counter with wrap at H_ACTIVE/V_ACTIVE.
  - Outputs `sof`, `eol` and `eof` flags.
  - The pattern mux stays in the top.

## Test plan
Parameters for all scenarios: H_ACTIVE = 16, V_ACTIVE = 4.
- Reset, then `enable_i` = 1, `tready` = 1, `pattern_sel_i` = 0 → first beat one cycle later with `tuser` = 1 and data FFFFFF. Beats 2,3 = FFFFFF/FFFF00. `tlast` on every 16th beat. 64 beats, then `frame_cnt_o` = 1.
- `tready` toggled by a random 30% stall pattern, gradient pattern → data on beat n equals n mod 16 in each channel. Outputs are stable during every stall. No beat is lost or duplicated.
- `enable_i` dropped at pixel (5,2) → the frame completes to 64 beats, then `tvalid` = 0 and `busy_o` = 0. `enable_i` held high across the frame end gives the next frame's `tuser` in the very next cycle.
- `pattern_sel_i` changed from 2 to 1 mid-frame with `color_i` = 123456 → the rest of the frame stays 123456. The next frame is a gradient.
- `rst_i` pulsed at beat 20 → `tvalid` = 0 next cycle and `frame_cnt_o` = 0. A restart begins at (0,0) with `tuser` = 1.
- Run with `FRAME_CNT_WIDTH` = 2 for 5 frames → `frame_cnt_o` reads 1, 2, 3, 0, 1 after successive frames.
